// File: rtl/reg_bank_reader_pkg.sv
// Shared types and sizing for the register-bank block reader.
package reg_bank_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/reg_bank_reader_fifo2.sv
// Two-entry shift FIFO; entry0 is always the head so the output needs no read mux.
module reg_bank_reader_fifo2
  import reg_bank_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
);

  logic [W-1:0]     entry0_q, entry0_d;
  logic [W-1:0]     entry1_q, entry1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_W'(FIFO_DEPTH));
  assign occupancy = occ_q;
  assign head      = entry0_q;
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (empty) entry0_d = push_data;
        else       entry1_d = push_data;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        entry0_d = entry1_q;
        occ_d    = occ_q - OCC_W'(1);
      end
      2'b11: begin
        // Occupancy is unchanged; the new word goes behind whatever remains.
        if (occ_q == OCC_W'(1)) begin
          entry0_d = push_data;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Walks a block of register-bank addresses (1-cycle read latency) and streams the
// words out over valid/ready, pulsing done once the last word has been accepted.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int A = 8,
  parameter int D = 8,
  parameter int R = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] base_addr,
  input  logic [A:0]   count,
  output logic         busy,
  output logic         done,
  output logic         rd_en,
  output logic [A-1:0] rd_addr,
  input  logic [D-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_data,
  output logic         out_last
);

  localparam logic [A:0] R_MAX   = (A+1)'(R);
  localparam logic [A:0] REM_ONE = (A+1)'(1);

  state_e           state_q, state_d;
  logic [A-1:0]     addr_q, addr_d;
  logic [A:0]       remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  logic [A:0]       count_clamped;
  logic             fifo_full, fifo_empty;
  logic [OCC_W-1:0] fifo_occ;
  logic [D:0]       fifo_head;
  logic [OCC_W:0]   pending;
  logic             pop, credit, issue;

  reg_bank_reader_fifo2 #(.W(D + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign count_clamped = (count > R_MAX) ? R_MAX : count;
  assign out_valid     = !fifo_empty;
  assign {out_last, out_data} = fifo_head;
  assign pop           = out_valid && out_ready;

  // A read may only issue if its data is guaranteed a FIFO slot when it lands.
  assign pending = (OCC_W+1)'(fifo_occ) + (OCC_W+1)'(inflight_q);
  assign credit  = (pending < (OCC_W+1)'(FIFO_DEPTH)) ||
                   ((pending == (OCC_W+1)'(FIFO_DEPTH)) && pop);
  assign issue   = (state_q == RUN) && (remaining_q != '0) && credit;

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == REM_ONE);
    done            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count_clamped;
          state_d     = (count_clamped == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_q + A'(1);
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish as soon as this cycle's pop leaves nothing buffered or in flight.
        if (!inflight_q && (fifo_empty || (pop && !fifo_full))) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader: a negedge monitor records DUT activity,
// each scenario task pushes expected words at start and compares afterwards.
module tb_reg_bank_reader;

  localparam int A = 8;
  localparam int D = 8;
  localparam int R = 256;

  logic         clk = 1'b0;
  logic         reset, start, out_ready;
  logic [A-1:0] base_addr;
  logic [A:0]   count;
  logic         busy, done, rd_en, out_valid, out_last;
  logic [A-1:0] rd_addr;
  logic [D-1:0] rd_data = '0;
  logic [D-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  logic [A-1:0] exp_addr[$];
  logic [D:0]   exp_word[$];

  logic [A-1:0] obs_addr[$];
  int           obs_addr_cyc[$];
  logic [D:0]   obs_word[$];
  int           obs_word_cyc[$];
  int           obs_done_cyc[$];
  int           cyc = 0;
  int           outstanding = 0;
  int           max_out = 0;
  int           proto_viol = 0;
  logic         prev_stall = 1'b0;
  logic         prev_done = 1'b0;
  logic [D:0]   prev_word = '0;

  reg_bank_reader #(.A(A), .D(D), .R(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Bank model: registered read, data = address ^ 0xA5.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr ^ 8'hA5;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (rd_en) begin
        obs_addr.push_back(rd_addr);
        obs_addr_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_word.push_back({out_last, out_data});
        obs_word_cyc.push_back(cyc);
      end
      if (done) obs_done_cyc.push_back(cyc);
      outstanding = outstanding + int'(rd_en) - int'(out_valid && out_ready);
      if (outstanding > max_out) max_out = outstanding;
      if (prev_stall && (!out_valid || ({out_last, out_data} !== prev_word))) proto_viol++;
      if (done && !busy) proto_viol++;
      if (prev_done && busy) proto_viol++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      prev_done  = done;
    end
  end

  task automatic issue_start(input logic [A-1:0] b, input logic [A:0] c);
    int n;
    logic [A-1:0] a;
    n = (int'(c) > R) ? R : int'(c);
    for (int i = 0; i < n; i++) begin
      a = b + A'(i);
      exp_addr.push_back(a);
      exp_word.push_back({(i == n - 1), a ^ 8'hA5});
    end
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0; base_addr = A'($urandom); count = (A+1)'($urandom);
  endtask

  task automatic wait_done(input int mode, input int budget, input int d0, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (k < budget && !ok) begin
      @(posedge clk); #1; k++;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = (k % 3 == 1);
      else                out_ready = 1'($urandom_range(0, 1));
      if (obs_done_cyc.size() > d0) ok = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    int w0, d0;
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, rd_en, rd_addr, out_valid, out_data, out_last} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, rd_en, rd_addr, out_valid, out_data, out_last});
    end
    reset = 1'b0; @(posedge clk); #1;
    exp_addr.delete(); exp_word.delete();
    issue_start(8'hC0, 9'd20);
    repeat (6) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({busy, done, rd_en, rd_addr, out_valid, out_data, out_last} !== '0) begin
        n_err++;
        $display("FAIL midreset_outputs[%0d]: got %h required 0", i, {busy, done, rd_en, rd_addr, out_valid, out_data, out_last});
      end
    end
    reset = 1'b0; out_ready = 1'b1;
    exp_addr.delete(); exp_word.delete();
    w0 = obs_word.size(); d0 = obs_done_cyc.size();
    issue_start(8'h40, 9'd3);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL start_after_reset_busy: got %b required 1", busy); end
    wait_done(0, 30, d0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_restart_done: no done within 30 cycles"); end
    n_vec++;
    if (obs_word.size() - w0 !== 3) begin n_err++; $display("FAIL reset_restart_words: got %0d required 3", obs_word.size() - w0); end
    for (int i = 0; i < 3 && w0 + i < obs_word.size(); i++) begin
      n_vec++;
      if (obs_word[w0+i] !== exp_word[i]) begin n_err++; $display("FAIL reset_restart_word[%0d]: got %h required %h", i, obs_word[w0+i], exp_word[i]); end
    end
  endtask

  task automatic test_stream();
    int a0, w0, d0, s, p0;
    bit ok;
    exp_addr.delete(); exp_word.delete();
    out_ready = 1'b1;
    a0 = obs_addr.size(); w0 = obs_word.size(); d0 = obs_done_cyc.size(); p0 = proto_viol;
    s = cyc + 1;
    issue_start(8'h10, 9'd4);
    wait_done(0, 40, d0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL stream_done: no done within 40 cycles"); end
    n_vec++;
    if (obs_addr.size() - a0 !== 4) begin n_err++; $display("FAIL stream_reads: got %0d required 4", obs_addr.size() - a0); end
    n_vec++;
    if (obs_word.size() - w0 !== 4) begin n_err++; $display("FAIL stream_words: got %0d required 4", obs_word.size() - w0); end
    for (int i = 0; i < 4; i++) begin
      if (a0 + i < obs_addr.size()) begin
        n_vec++;
        if (obs_addr[a0+i] !== exp_addr[i] || obs_addr_cyc[a0+i] !== s + 1 + i) begin
          n_err++;
          $display("FAIL stream_rd[%0d]: got addr %h at cycle %0d required %h at %0d", i, obs_addr[a0+i], obs_addr_cyc[a0+i], exp_addr[i], s + 1 + i);
        end
      end
      if (w0 + i < obs_word.size()) begin
        n_vec++;
        if (obs_word[w0+i] !== exp_word[i] || obs_word_cyc[w0+i] !== obs_word_cyc[w0] + i) begin
          n_err++;
          $display("FAIL stream_word[%0d]: got %h at cycle %0d required %h at %0d", i, obs_word[w0+i], obs_word_cyc[w0+i], exp_word[i], obs_word_cyc[w0] + i);
        end
      end
    end
    if (ok && obs_word.size() - w0 == 4) begin
      n_vec++;
      if (obs_done_cyc[d0] !== obs_word_cyc[w0+3] + 1) begin
        n_err++;
        $display("FAIL stream_done_cycle: got %0d required %0d", obs_done_cyc[d0], obs_word_cyc[w0+3] + 1);
      end
    end
    n_vec++;
    if (proto_viol !== p0) begin n_err++; $display("FAIL stream_protocol: got %0d violations required 0", proto_viol - p0); end
  endtask

  task automatic test_backpressure();
    int w0, d0, p0;
    bit ok;
    exp_addr.delete(); exp_word.delete();
    out_ready = 1'b1;
    w0 = obs_word.size(); d0 = obs_done_cyc.size(); p0 = proto_viol;
    issue_start(8'h00, 9'd6);
    wait_done(1, 80, d0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_done: no done within 80 cycles"); end
    n_vec++;
    if (obs_word.size() - w0 !== 6) begin n_err++; $display("FAIL bp_words: got %0d required 6", obs_word.size() - w0); end
    for (int i = 0; i < 6 && w0 + i < obs_word.size(); i++) begin
      n_vec++;
      if (obs_word[w0+i] !== exp_word[i]) begin n_err++; $display("FAIL bp_word[%0d]: got %h required %h", i, obs_word[w0+i], exp_word[i]); end
    end
    n_vec++;
    if (max_out > 2) begin n_err++; $display("FAIL bp_outstanding: got %0d required <= 2", max_out); end
    n_vec++;
    if (proto_viol !== p0) begin n_err++; $display("FAIL bp_stall_stable: got %0d violations required 0", proto_viol - p0); end
  endtask

  task automatic test_wrap();
    int a0, w0, d0;
    bit ok;
    exp_addr.delete(); exp_word.delete();
    a0 = obs_addr.size(); w0 = obs_word.size(); d0 = obs_done_cyc.size();
    issue_start(8'hFE, 9'd4);
    wait_done(2, 60, d0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap_done: no done within 60 cycles"); end
    for (int i = 0; i < 4 && a0 + i < obs_addr.size(); i++) begin
      n_vec++;
      if (obs_addr[a0+i] !== exp_addr[i]) begin n_err++; $display("FAIL wrap_rd_addr[%0d]: got %h required %h", i, obs_addr[a0+i], exp_addr[i]); end
    end
    n_vec++;
    if (obs_word.size() - w0 !== 4) begin
      n_err++; $display("FAIL wrap_words: got %0d required 4", obs_word.size() - w0);
    end else if (obs_word[w0+3] !== 9'h1A4 || obs_word[w0+2][D] !== 1'b0) begin
      n_err++; $display("FAIL wrap_last: got %h,%h required 0a5,1a4", obs_word[w0+2], obs_word[w0+3]);
    end
  endtask

  task automatic test_edge_counts();
    int a0, w0, d0, s, miss, dup;
    int cnts[2];
    bit ok;
    bit seen[256];
    cnts[0] = 256; cnts[1] = 300;
    exp_addr.delete(); exp_word.delete();
    a0 = obs_addr.size(); w0 = obs_word.size(); d0 = obs_done_cyc.size();
    s = cyc + 1;
    issue_start(8'h33, 9'd0);
    wait_done(0, 10, d0, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL zero_done: no done within 10 cycles");
    end else if (obs_done_cyc[d0] - s < 1 || obs_done_cyc[d0] - s > 2) begin
      n_err++; $display("FAIL zero_done_latency: got %0d cycles required 1..2", obs_done_cyc[d0] - s);
    end
    n_vec++;
    if (obs_addr.size() - a0 !== 0 || obs_word.size() - w0 !== 0) begin
      n_err++; $display("FAIL zero_activity: got %0d reads %0d words required 0 0", obs_addr.size() - a0, obs_word.size() - w0);
    end
    for (int j = 0; j < 2; j++) begin
      exp_addr.delete(); exp_word.delete();
      a0 = obs_addr.size(); w0 = obs_word.size(); d0 = obs_done_cyc.size();
      issue_start(8'h5A, 9'(cnts[j]));
      wait_done(0, 600, d0, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL full_done[%0d]: no done within 600 cycles", cnts[j]); end
      n_vec++;
      if (obs_addr.size() - a0 !== 256) begin n_err++; $display("FAIL full_reads[%0d]: got %0d required 256", cnts[j], obs_addr.size() - a0); end
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      dup = 0; miss = 0;
      for (int i = a0; i < obs_addr.size(); i++) begin
        if (seen[obs_addr[i]]) dup++;
        seen[obs_addr[i]] = 1'b1;
      end
      for (int i = 0; i < 256; i++) if (!seen[i]) miss++;
      n_vec++;
      if (dup !== 0 || miss !== 0) begin n_err++; $display("FAIL full_cover[%0d]: got %0d dup %0d missing required 0 0", cnts[j], dup, miss); end
      n_vec++;
      if (obs_word.size() - w0 !== 256) begin n_err++; $display("FAIL full_words[%0d]: got %0d required 256", cnts[j], obs_word.size() - w0); end
      for (int i = 0; i < 256 && w0 + i < obs_word.size(); i++) begin
        n_vec++;
        if (obs_word[w0+i] !== exp_word[i]) begin n_err++; $display("FAIL full_word[%0d][%0d]: got %h required %h", cnts[j], i, obs_word[w0+i], exp_word[i]); end
      end
    end
  endtask

  task automatic test_abort_ignore();
    int a0, w0, d0, k;
    bit ok;
    exp_addr.delete(); exp_word.delete();
    out_ready = 1'b1;
    a0 = obs_addr.size(); w0 = obs_word.size(); d0 = obs_done_cyc.size();
    issue_start(8'h30, 9'd5);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h99; count = 9'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 40, d0, ok);
    n_vec++;
    if (!ok || obs_done_cyc.size() - d0 !== 1) begin n_err++; $display("FAIL ignore_done: got %0d done pulses required 1", obs_done_cyc.size() - d0); end
    n_vec++;
    if (obs_addr.size() - a0 !== 5 || obs_word.size() - w0 !== 5) begin
      n_err++; $display("FAIL ignore_counts: got %0d reads %0d words required 5 5", obs_addr.size() - a0, obs_word.size() - w0);
    end else begin
      n_vec++;
      if (obs_addr[a0] !== 8'h30 || obs_word[w0+4] !== exp_word[4]) begin
        n_err++; $display("FAIL ignore_data: got addr %h last %h required 30 %h", obs_addr[a0], obs_word[w0+4], exp_word[4]);
      end
    end
    // Abort after two of five words have been delivered.
    exp_addr.delete(); exp_word.delete();
    w0 = obs_word.size(); d0 = obs_done_cyc.size();
    issue_start(8'h60, 9'd5);
    k = 0;
    while (k < 20 && obs_word.size() < w0 + 2) begin @(posedge clk); #1; k++; end
    n_vec++;
    if (obs_word.size() < w0 + 2) begin n_err++; $display("FAIL abort_wait: got %0d words required 2", obs_word.size() - w0); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: got rd_en=%b out_valid=%b busy=%b required 0 0 0", rd_en, out_valid, busy);
    end
    reset = 1'b0;
    a0 = obs_addr.size();
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (obs_done_cyc.size() !== d0 || obs_addr.size() !== a0) begin
      n_err++; $display("FAIL abort_no_done: got %0d done %0d reads required 0 0", obs_done_cyc.size() - d0, obs_addr.size() - a0);
    end
    exp_addr.delete(); exp_word.delete();
    w0 = obs_word.size(); d0 = obs_done_cyc.size();
    issue_start(8'h70, 9'd3);
    wait_done(0, 30, d0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL abort_restart_done: no done within 30 cycles"); end
    n_vec++;
    if (obs_word.size() - w0 !== 3) begin n_err++; $display("FAIL abort_restart_words: got %0d required 3", obs_word.size() - w0); end
    for (int i = 0; i < 3 && w0 + i < obs_word.size(); i++) begin
      n_vec++;
      if (obs_word[w0+i] !== exp_word[i]) begin n_err++; $display("FAIL abort_restart_word[%0d]: got %h required %h", i, obs_word[w0+i], exp_word[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_edge_counts();
    test_abort_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
